fmap_ram_arbiter: RTL

FMAP_RAM_ARBITER -- requirements
Module: fmap_ram_arbiter

---
 rtl/fmap_ram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fmap_ram_arbiter.sv
// ---------------------------------------------------------------------------
// fmap_ram_arbiter
//
// Shares one single-port feature-map RAM between three requesters:
//   - a conv/ReLU write port (highest priority),
//   - a max-pooling read port (rd0),
//   - a host readback port (rd1).
// The two readers share the RAM round-robin. To stop a continuous write stream
// from starving a waiting reader, the writer may take at most WR_BURST_MAX
// consecutive grants while a reader is requesting. After that, one reader
// grant is forced in.
//
// Grants are combinational: a request is transferred in the cycle where
// req & gnt are both high. The RAM read data arrives one cycle after the read
// grant. It is returned on the matching rdX_data with a one-cycle rdX_valid.
//
// Ports
//   clk, rst_n                    single rising-edge clock, synchronous
//                                 active-low reset
//   wr_req/wr_addr/wr_data        write request, held until wr_gnt
//   wr_gnt                        write performed this cycle
//   rd0_req/rd0_addr, rd0_gnt     max-pooling read request / grant
//   rd0_valid/rd0_data            read return, one cycle after rd0_gnt
//   rd1_*                         host readback port, same shape as rd0
//   ram_we/ram_addr/ram_din       single-port RAM command
//   ram_dout                      RAM read data, one cycle after the address
//   wr_stall_cnt                  saturating count of stalled write cycles
// ---------------------------------------------------------------------------
module fmap_ram_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int WR_BURST_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,

    input  logic                  rd0_req,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_gnt,
    output logic                  rd0_valid,
    output logic [DATA_WIDTH-1:0] rd0_data,

    input  logic                  rd1_req,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_gnt,
    output logic                  rd1_valid,
    output logic [DATA_WIDTH-1:0] rd1_data,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,

    output logic [15:0]           wr_stall_cnt
);

    // The burst counter must be able to hold WR_BURST_MAX itself. A value of
    // 0 is legal and means a waiting reader always beats the writer.
    localparam int BW = (WR_BURST_MAX < 1) ? 1 : $clog2(WR_BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(WR_BURST_MAX);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_WR,
        SEL_RD0,
        SEL_RD1
    } sel_e;

    sel_e          sel;
    logic          any_rd;
    logic          burst_hold;
    logic [BW-1:0] burst_cnt;
    logic          rr_rd1;      // 1: rd1 wins the next read tie, 0: rd0 wins

    // -----------------------------------------------------------------------
    // Grant selection
    // -----------------------------------------------------------------------
    assign any_rd     = rd0_req | rd1_req;
    assign burst_hold = (burst_cnt == BURST_MAX) && any_rd;

    // NOTE: every variable assigned in a combinational block gets a default
    // first. Otherwise a path that skips the assignment infers a latch.
    always_comb begin
        sel = SEL_NONE;
        if (!rst_n) begin
            sel = SEL_NONE;
        end else if (wr_req && !burst_hold) begin
            sel = SEL_WR;
        end else if (rd0_req && rd1_req) begin
            sel = rr_rd1 ? SEL_RD1 : SEL_RD0;
        end else if (rd0_req) begin
            sel = SEL_RD0;
        end else if (rd1_req) begin
            sel = SEL_RD1;
        end
    end

    assign wr_gnt  = (sel == SEL_WR);
    assign rd0_gnt = (sel == SEL_RD0);
    assign rd1_gnt = (sel == SEL_RD1);

    // -----------------------------------------------------------------------
    // RAM command mux. Idle cycles drive zeros, not the last address.
    // -----------------------------------------------------------------------
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (sel)
            SEL_WR: begin
                ram_we   = 1'b1;
                ram_addr = wr_addr;
                ram_din  = wr_data;
            end
            SEL_RD0:  ram_addr = rd0_addr;
            SEL_RD1:  ram_addr = rd1_addr;
            default: ;
        endcase
    end

    // Read data is only presented during its valid cycle.
    assign rd0_data = rd0_valid ? ram_dout : '0;
    assign rd1_data = rd1_valid ? ram_dout : '0;

    // -----------------------------------------------------------------------
    // State: read-return tags, round-robin pointer, burst and stall counters
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together at the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd0_valid    <= 1'b0;
            rd1_valid    <= 1'b0;
            rr_rd1       <= 1'b0;
            burst_cnt    <= '0;
            wr_stall_cnt <= '0;
        end else begin
            // The RAM read latency is one cycle, so the valid is the grant
            // delayed by one cycle. Back-to-back grants give back-to-back
            // valids.
            rd0_valid <= (sel == SEL_RD0);
            rd1_valid <= (sel == SEL_RD1);

            // The pointer moves only on a read grant. It always favours the
            // reader that was not served last.
            if (sel == SEL_RD0) begin
                rr_rd1 <= 1'b1;
            end else if (sel == SEL_RD1) begin
                rr_rd1 <= 1'b0;
            end

            // Count consecutive write grants. The count saturates at the
            // limit, so a reader that arrives during a long write stream is
            // served on its first request cycle. Any cycle without a write
            // grant, including a forced reader cycle, clears the count.
            if (sel == SEL_WR) begin
                if (burst_cnt != BURST_MAX) begin
                    burst_cnt <= burst_cnt + BW'(1);
                end
            end else begin
                burst_cnt <= '0;
            end

            if (wr_req && (sel != SEL_WR) && (wr_stall_cnt != 16'hFFFF)) begin
                wr_stall_cnt <= wr_stall_cnt + 16'd1;
            end
        end
    end

endmodule
